// File: rtl/ahb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : ahb_pkg
// Brief   : Shared AHB encodings and arbiter state type for the bridge arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package ahb_pkg;

    localparam int MAX_MASTERS = 4;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [0:0] {
        ARB_PARK  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/ahb_bridge_arbiter_rr_pick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin selector; first requester at or after
//           i_ptr wins, returned both one-hot and as an index.
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 2
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [1:0]             i_ptr,
    output logic [NUM_MASTERS-1:0] o_gnt,
    output logic [1:0]             o_idx,
    output logic                   o_any
);

    logic [MAX_MASTERS-1:0] w_req_pad;
    logic [MAX_MASTERS-1:0] w_gnt_pad;
    logic [1:0]             w_pos;

    assign w_req_pad = MAX_MASTERS'(i_req);

    // Walk from the farthest candidate back to i_ptr so the nearest one wins.
    always_comb begin
        w_gnt_pad = '0;
        w_pos     = '0;
        o_idx     = '0;
        o_any     = 1'b0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            w_pos = 2'((int'(i_ptr) + k) % NUM_MASTERS);
            if (w_req_pad[w_pos]) begin
                w_gnt_pad = MAX_MASTERS'(1) << w_pos;
                o_idx     = w_pos;
                o_any     = 1'b1;
            end
        end
    end

    assign o_gnt = w_gnt_pad[NUM_MASTERS-1:0];

endmodule
`default_nettype wire

// File: rtl/ahb_bridge_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : ahb_bridge_arbiter
// Brief   : Round-robin AHB-Lite arbiter with bounded hold time in front of
//           the AHB-to-APB bridge. Optional master lock via AHB_ARB_LOCK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module ahb_bridge_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int MAX_HOLD    = 16
) (
    input  logic                      hclk,
    input  logic                      hreset,
    input  logic [NUM_MASTERS-1:0]    m_hbusreq,
    input  logic [2*NUM_MASTERS-1:0]  m_htrans,
    input  logic [32*NUM_MASTERS-1:0] m_haddr,
    input  logic [NUM_MASTERS-1:0]    m_hwrite,
    input  logic [32*NUM_MASTERS-1:0] m_hwdata,
`ifdef AHB_ARB_LOCK_EN
    input  logic [NUM_MASTERS-1:0]    m_hlock,
`endif
    output logic [NUM_MASTERS-1:0]    m_hgrant,
    output logic                      m_hready,
    output logic [31:0]               m_hrdata,
    output logic [1:0]                hmaster,
    output logic [1:0]                s_htrans,
    output logic [31:0]               s_haddr,
    output logic                      s_hwrite,
    output logic [31:0]               s_hwdata,
    output logic                      s_hready_in,
    input  logic                      s_hready_out,
    input  logic [31:0]               s_hrdata
);

    localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);
    localparam logic [1:0] c_last_idx = 2'(NUM_MASTERS - 1);

    logic [1:0]             w_htrans [MAX_MASTERS];
    logic [31:0]            w_haddr  [MAX_MASTERS];
    logic [31:0]            w_hwdata [MAX_MASTERS];
    logic [MAX_MASTERS-1:0] w_hwrite;
    logic [MAX_MASTERS-1:0] w_req;
    logic [MAX_MASTERS-1:0] w_lock;

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [NUM_MASTERS-1:0] r_hgrant;
    logic [1:0]             r_hmaster;
    logic [1:0]             r_rr_ptr;
    logic [7:0]             r_hold;
    logic [1:0]             r_data_owner;
    logic                   r_data_valid;

    logic [NUM_MASTERS-1:0] w_pick_gnt;
    logic [1:0]             w_pick_idx;
    logic                   w_pick_any;
    logic                   w_arb;
    logic                   w_release;
    logic                   w_others;
    logic                   w_expired;
    logic                   w_count;

    // Pad per-master buses to MAX_MASTERS so 2-bit indices never run off the end.
    for (genvar gi = 0; gi < MAX_MASTERS; gi++) begin : g_unpack
        if (gi < NUM_MASTERS) begin : g_used
            assign w_htrans[gi] = m_htrans[2*gi +: 2];
            assign w_haddr[gi]  = m_haddr[32*gi +: 32];
            assign w_hwdata[gi] = m_hwdata[32*gi +: 32];
            assign w_hwrite[gi] = m_hwrite[gi];
            assign w_req[gi]    = m_hbusreq[gi];
`ifdef AHB_ARB_LOCK_EN
            assign w_lock[gi]   = m_hlock[gi];
`else
            assign w_lock[gi]   = 1'b0;
`endif
        end else begin : g_unused
            assign w_htrans[gi] = '0;
            assign w_haddr[gi]  = '0;
            assign w_hwdata[gi] = '0;
            assign w_hwrite[gi] = 1'b0;
            assign w_req[gi]    = 1'b0;
            assign w_lock[gi]   = 1'b0;
        end
    end

    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_rr_pick (
        .i_req (m_hbusreq),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    assign w_others  = |(w_req & ~(MAX_MASTERS'(1) << r_hmaster));
    assign w_expired = (r_hold >= c_max_hold);
    // A SEQ beat is never cut, so expiry only bites on the next non-SEQ transfer.
    assign w_release = (s_htrans == HTRANS_IDLE) || !w_req[r_hmaster] ||
                       (w_expired && (s_htrans != HTRANS_SEQ));
    assign w_count   = s_hready_out && (r_state == ARB_OWNED) &&
                       (s_htrans != HTRANS_IDLE) && w_others && (r_hold < c_max_hold);

    always_comb begin
        w_state_nxt = r_state;
        w_arb       = 1'b0;
        case (r_state)
            ARB_PARK:  w_arb = s_hready_out;
            ARB_OWNED: w_arb = s_hready_out && !w_lock[r_hmaster] && w_release;
            default:   w_arb = 1'b0;
        endcase
        if (w_arb) begin
            w_state_nxt = w_pick_any ? ARB_OWNED : ARB_PARK;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state <= ARB_PARK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_hgrant     <= NUM_MASTERS'(1);
            r_hmaster    <= '0;
            r_rr_ptr     <= '0;
            r_hold       <= '0;
            r_data_owner <= '0;
            r_data_valid <= 1'b0;
        end else begin
            if (w_arb && w_pick_any) begin
                r_hgrant  <= w_pick_gnt;
                r_hmaster <= w_pick_idx;
                r_rr_ptr  <= (w_pick_idx == c_last_idx) ? 2'd0 : w_pick_idx + 2'd1;
            end
            // A fresh tenure (new owner or leaving PARK) starts its hold budget at zero.
            if (w_arb && w_pick_any && ((w_pick_idx != r_hmaster) || (r_state == ARB_PARK))) begin
                r_hold <= '0;
            end else if (w_count) begin
                r_hold <= r_hold + 8'd1;
            end
            if (s_hready_out) begin
                r_data_owner <= r_hmaster;
                r_data_valid <= s_htrans[1];
            end
        end
    end

    assign m_hgrant    = r_hgrant;
    assign hmaster     = r_hmaster;
    assign s_htrans    = w_htrans[r_hmaster];
    assign s_haddr     = w_haddr[r_hmaster];
    assign s_hwrite    = w_hwrite[r_hmaster];
    assign s_hwdata    = r_data_valid ? w_hwdata[r_data_owner] : 32'd0;
    assign m_hready    = s_hready_out;
    assign s_hready_in = s_hready_out;
    assign m_hrdata    = s_hrdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_bridge_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_ahb_bridge_arbiter
// Brief   : Directed self-checking bench; bridge-side scoreboard for transfers.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ahb_bridge_arbiter;
    import ahb_pkg::*;

    localparam int NUM_MASTERS = 2;
    localparam int MAX_HOLD    = 4;

    logic                      hclk;
    logic                      hreset;
    logic [NUM_MASTERS-1:0]    m_hbusreq;
    logic [2*NUM_MASTERS-1:0]  m_htrans;
    logic [32*NUM_MASTERS-1:0] m_haddr;
    logic [NUM_MASTERS-1:0]    m_hwrite;
    logic [32*NUM_MASTERS-1:0] m_hwdata;
`ifdef AHB_ARB_LOCK_EN
    logic [NUM_MASTERS-1:0]    m_hlock;
`endif
    logic [NUM_MASTERS-1:0]    m_hgrant;
    logic                      m_hready;
    logic [31:0]               m_hrdata;
    logic [1:0]                hmaster;
    logic [1:0]                s_htrans;
    logic [31:0]               s_haddr;
    logic                      s_hwrite;
    logic [31:0]               s_hwdata;
    logic                      s_hready_in;
    logic                      s_hready_out;
    logic [31:0]               s_hrdata;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t       sb[$];
    int          errors;
    int          checks;
    logic        dp_valid;
    logic [31:0] dp_addr;
    logic        dp_write;

    ahb_bridge_arbiter #(
        .NUM_MASTERS (NUM_MASTERS),
        .MAX_HOLD    (MAX_HOLD)
    ) dut (
        .hclk         (hclk),
        .hreset       (hreset),
        .m_hbusreq    (m_hbusreq),
        .m_htrans     (m_htrans),
        .m_haddr      (m_haddr),
        .m_hwrite     (m_hwrite),
        .m_hwdata     (m_hwdata),
`ifdef AHB_ARB_LOCK_EN
        .m_hlock      (m_hlock),
`endif
        .m_hgrant     (m_hgrant),
        .m_hready     (m_hready),
        .m_hrdata     (m_hrdata),
        .hmaster      (hmaster),
        .s_htrans     (s_htrans),
        .s_haddr      (s_haddr),
        .s_hwrite     (s_hwrite),
        .s_hwdata     (s_hwdata),
        .s_hready_in  (s_hready_in),
        .s_hready_out (s_hready_out),
        .s_hrdata     (s_hrdata)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input int i, input logic [1:0] t, input logic [31:0] a,
                         input logic w, input logic [31:0] d);
        m_htrans[2*i +: 2]  = t;
        m_haddr[32*i +: 32] = a;
        m_hwrite[i]         = w;
        m_hwdata[32*i +: 32] = d;
    endtask

    task automatic push(input logic [31:0] a, input logic w, input logic [31:0] d);
        xfer_t e;
        e.addr  = a;
        e.write = w;
        e.wdata = d;
        sb.push_back(e);
    endtask

    // Bridge-side monitor: a transfer completes at the first ready edge after its address phase.
    always @(negedge hclk) begin
        xfer_t e;
        if (hreset) begin
            dp_valid <= 1'b0;
        end else if (s_hready_out) begin
            if (dp_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_pending", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("bridge_addr", dp_addr, e.addr);
                    chk("bridge_write", 32'(dp_write), 32'(e.write));
                    if (e.write) chk("bridge_wdata", s_hwdata, e.wdata);
                end
            end
            dp_valid <= s_htrans[1];
            dp_addr  <= s_haddr;
            dp_write <= s_hwrite;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        errors       = 0;
        checks       = 0;
        hreset       = 1'b1;
        m_hbusreq    = '0;
        m_htrans     = '0;
        m_haddr      = '0;
        m_hwrite     = '0;
        m_hwdata     = '0;
        s_hready_out = 1'b1;
        s_hrdata     = 32'hCAFE_F00D;
`ifdef AHB_ARB_LOCK_EN
        m_hlock      = '0;
`endif
        tick();
        tick();

        // Reset state and broadcast paths
        chk("rst_hgrant", 32'(m_hgrant), 32'd1);
        chk("rst_hmaster", 32'(hmaster), 32'd0);
        chk("rst_hwdata", s_hwdata, 32'd0);
        drive(0, HTRANS_NONSEQ, 32'h0000_0010, 1'b0, 32'd0);
        drive(1, HTRANS_SEQ, 32'h0000_0020, 1'b1, 32'd0);
        #1;
        chk("rst_htrans_m0", 32'(s_htrans), 32'd2);
        chk("rst_haddr_m0", s_haddr, 32'h0000_0010);
        chk("hrdata_bcast", m_hrdata, 32'hCAFE_F00D);
        chk("hready_bcast", 32'(m_hready), 32'd1);
        chk("hready_in", 32'(s_hready_in), 32'd1);
        drive(0, HTRANS_IDLE, 32'd0, 1'b0, 32'd0);
        drive(1, HTRANS_IDLE, 32'd0, 1'b0, 32'd0);
        hreset = 1'b0;
        tick();

        // Single master 1 write
        m_hbusreq[1] = 1'b1;
        tick();
        chk("t1_grant", 32'(m_hgrant), 32'd2);
        chk("t1_hmaster", 32'(hmaster), 32'd1);
        drive(1, HTRANS_NONSEQ, 32'h8000_0010, 1'b1, 32'd0);
        push(32'h8000_0010, 1'b1, 32'hA5A5_0001);
        #1;
        chk("t1_htrans", 32'(s_htrans), 32'd2);
        chk("t1_haddr", s_haddr, 32'h8000_0010);
        tick();
        drive(1, HTRANS_IDLE, 32'd0, 1'b0, 32'hA5A5_0001);
        m_hbusreq[1] = 1'b0;
        #1;
        chk("t1_hwdata", s_hwdata, 32'hA5A5_0001);
        tick();
        chk("t1_park_grant", 32'(m_hgrant), 32'd2);
        chk("t1_park_hmaster", 32'(hmaster), 32'd1);

        // Async reset, then simultaneous requests
        hreset = 1'b1;
        #1;
        chk("t2_async_grant", 32'(m_hgrant), 32'd1);
        chk("t2_async_hmaster", 32'(hmaster), 32'd0);
        hreset = 1'b0;
        m_hbusreq = 2'b11;
        tick();
        chk("t2_first_grant", 32'(m_hgrant), 32'd1);
        chk("t2_first_hmaster", 32'(hmaster), 32'd0);
        drive(0, HTRANS_NONSEQ, 32'h0000_0100, 1'b1, 32'd0);
        push(32'h0000_0100, 1'b1, 32'h1111_0000);
        tick();
        drive(0, HTRANS_IDLE, 32'd0, 1'b0, 32'h1111_0000);
        #1;
        chk("t2_keep_grant", 32'(m_hgrant), 32'd1);
        chk("t2_hwdata", s_hwdata, 32'h1111_0000);
        tick();
        chk("t2_handover_grant", 32'(m_hgrant), 32'd2);
        chk("t2_handover_hmaster", 32'(hmaster), 32'd1);

        // Bridge wait states during a handover
        drive(1, HTRANS_NONSEQ, 32'h0000_0200, 1'b1, 32'd0);
        push(32'h0000_0200, 1'b1, 32'h2222_0000);
        tick();
        drive(1, HTRANS_IDLE, 32'd0, 1'b0, 32'h2222_0000);
        drive(0, HTRANS_IDLE, 32'd0, 1'b0, 32'hDEAD_BEEF);
        s_hready_out = 1'b0;
        #1;
        chk("t3_mready", 32'(m_hready), 32'd0);
        for (int w = 0; w < 3; w++) begin
            tick();
            chk("t3_ws_grant", 32'(m_hgrant), 32'd2);
            chk("t3_ws_hmaster", 32'(hmaster), 32'd1);
            chk("t3_ws_hwdata", s_hwdata, 32'h2222_0000);
        end
        s_hready_out = 1'b1;
        tick();
        chk("t3_release_grant", 32'(m_hgrant), 32'd1);
        chk("t3_release_hmaster", 32'(hmaster), 32'd0);

        // 8-beat INCR by master 0 while master 1 waits
        for (int k = 0; k < 8; k++) begin
            drive(0, (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 32'h0000_0300 + 32'(4 * k), 1'b1,
                  (k == 0) ? 32'd0 : 32'h3000_0000 + 32'(k - 1));
            push(32'h0000_0300 + 32'(4 * k), 1'b1, 32'h3000_0000 + 32'(k));
            tick();
            chk("t4_burst_grant", 32'(m_hgrant), 32'd1);
        end
        drive(0, HTRANS_NONSEQ, 32'h0000_0400, 1'b1, 32'h3000_0007);
        push(32'h0000_0400, 1'b1, 32'h4000_0000);
        tick();
        chk("t4_expiry_grant", 32'(m_hgrant), 32'd2);
        chk("t4_expiry_hmaster", 32'(hmaster), 32'd1);
        drive(0, HTRANS_IDLE, 32'd0, 1'b0, 32'h4000_0000);
        m_hbusreq[0] = 1'b0;
        #1;
        chk("t4_split_hwdata", s_hwdata, 32'h4000_0000);

        // Reset mid-burst by master 1
        drive(1, HTRANS_NONSEQ, 32'h0000_0600, 1'b1, 32'd0);
        tick();
        drive(1, HTRANS_SEQ, 32'h0000_0604, 1'b1, 32'h6000_0000);
        #1;
        chk("t5_pre_hwdata", s_hwdata, 32'h6000_0000);
        hreset = 1'b1;
        #1;
        chk("t5_rst_grant", 32'(m_hgrant), 32'd1);
        chk("t5_rst_hmaster", 32'(hmaster), 32'd0);
        chk("t5_rst_hwdata", s_hwdata, 32'd0);
        chk("t5_rst_htrans", 32'(s_htrans), 32'd0);
        tick();
        hreset = 1'b0;
        drive(1, HTRANS_IDLE, 32'd0, 1'b0, 32'd0);
        m_hbusreq = '0;
        tick();

`ifdef AHB_ARB_LOCK_EN
        // Locked owner is never pre-empted
        m_hbusreq[1] = 1'b1;
        m_hlock[1]   = 1'b1;
        tick();
        chk("lk_grant", 32'(m_hgrant), 32'd2);
        m_hbusreq[0] = 1'b1;
        for (int j = 0; j < 24; j++) begin
            if (j % 5 == 4) begin
                drive(1, HTRANS_IDLE, 32'd0, 1'b0, 32'd0);
            end else begin
                drive(1, HTRANS_NONSEQ, 32'h0000_0700 + 32'(4 * j), 1'b0, 32'd0);
                push(32'h0000_0700 + 32'(4 * j), 1'b0, 32'd0);
            end
            tick();
            chk("lk_hold_grant", 32'(m_hgrant), 32'd2);
        end
        drive(1, HTRANS_IDLE, 32'd0, 1'b0, 32'd0);
        m_hlock[1] = 1'b0;
        tick();
        chk("lk_release_grant", 32'(m_hgrant), 32'd1);
        chk("lk_release_hmaster", 32'(hmaster), 32'd0);
        m_hbusreq = '0;
        tick();
`endif

        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
